phivers_flit_sink: RTL
======================

Name: phivers_flit_sink

Overview:
- Credit-based flit receiver. It is the consuming end of the rx/credit/data link that the MA and application injectors drive into the many-core.
- Attaches to a PE local or boundary output port and accepts packets as header flit, size flit, then size payload flits.
- Buffers flits in a FIFO and re-emits them on a valid/ready stream tagged with start-of-packet and end-of-packet.
- Flags malformed or oversized packets; used by benches and by off-chip bridges.

Parameters:
- FLIT_SIZE, 32: flit width in bits.
- BUFFER_DEPTH, 8: FIFO entries; must be a power of two and at least 2.
- MAX_PAYLOAD, 1024: largest legal size-flit value.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- rx_i  in  1  sender presents a flit on data_i.
- credit_o  out  1  sink can accept a flit this cycle.
- data_i  in  FLIT_SIZE  incoming flit.
- pkt_valid_o  out  1  pkt_data_o is valid.
- pkt_ready_i  in  1  consumer accepts the current flit.
- pkt_data_o  out  FLIT_SIZE  buffered flit.
- pkt_sop_o  out  1  flit is a packet header.
- pkt_eop_o  out  1  flit is the last flit of its packet.
- size_err_o  out  1  sticky: a size flit exceeded MAX_PAYLOAD.
- busy_o  out  1  input FSM is mid-packet (not in S_HEADER).

Behaviour:
- Reset: one clock and one synchronous active-high reset; on rst_i high at a clk_i edge the block is reset. Reset values: credit_o=0 while rst_i is high; pkt_valid_o=0; pkt_sop_o=0; pkt_eop_o=0; pkt_data_o=0; size_err_o=0; busy_o=0. FIFO is emptied, FSM goes to S_HEADER, payload counter is 0. Reset mid-packet discards all partial state.
- Input handshake: a flit transfers on any edge where rx_i && credit_o. When rst_i is low, credit_o = !fifo_full, driven combinationally from registered occupancy. rx_i while credit_o=0 is ignored; the sender holds the flit.
- Input FSM (advances only on a transfer):
  - S_HEADER: store the flit with sop=1, eop=0; go to S_SIZE.
  - S_SIZE: store the flit with sop=0. Load the counter with data_i at full FLIT_SIZE width. If data_i > MAX_PAYLOAD, set size_err_o. If data_i==0, set eop=1 and go to S_HEADER; otherwise eop=0 and go to S_PAYLOAD.
  - S_PAYLOAD: store the flit and decrement the counter. When the counter is 1 before the decrement, set eop=1 and go to S_HEADER.
- Oversized packets are still forwarded in full so the link stays framed.
- FIFO: each entry holds {sop, eop, data}, with BUFFER_DEPTH entries. Read and write pointers are clog2(BUFFER_DEPTH) bits and wrap naturally; the occupancy counter is clog2(BUFFER_DEPTH)+1 bits.
- Output: show-ahead. pkt_valid_o = !fifo_empty; pkt_data_o, pkt_sop_o and pkt_eop_o come from the head entry. A pop occurs on pkt_valid_o && pkt_ready_i. Output must stay stable while pkt_valid_o && !pkt_ready_i.
- Latency: a flit accepted at edge N is visible on the output after edge N, i.e. in cycle N+1.
- Boundaries:
  - Push and pop in the same cycle leave occupancy unchanged.
  - When full, credit_o=0. A pop at edge N raises credit_o in cycle N+1; a push is never accepted into a full FIFO.
  - When empty, pkt_valid_o=0 and pkt_ready_i is ignored.
- size_err_o clears only on reset.

Optional Feature:
- Macro PHIVERS_SINK_STATS_EN.
- Defined: adds outputs pkt_count_o (32 bits) and flit_count_o (32 bits), both reset to 0.
  - pkt_count_o increments on each output pop with eop.
  - flit_count_o increments on each input transfer.
  - Both wrap modulo 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- PhiversPkg gains sink_state_t (S_HEADER, S_SIZE, S_PAYLOAD) and the sink_entry_t packed struct {sop, eop, data}.
- One sub-module: phivers_sink_fifo, parameterised on width and depth, providing push/pop/full/empty and show-ahead output. The FSM and flow control stay in phivers_flit_sink.

Test Plan:
- Reset 5 cycles, rx_i=1 → credit_o=0 and pkt_valid_o=0 throughout. Release → credit_o=1 in the first cycle after reset deasserts.
- Packet 0x00000101, 0x2, 0xAAAA, 0xBBBB with ready=1 → output 0x101 (sop), 0x2, 0xAAAA, 0xBBBB (eop). Each flit appears one cycle after its transfer; busy_o falls after 0xBBBB.
- Size-0 packet 0x0202, 0x0 → two outputs; the second carries eop=1; FSM returns to S_HEADER; busy_o=0.
- Depth 8, ready=0, header + size 20 → exactly 8 flits accepted, then credit_o=0. Assert ready for one cycle → credit_o=1 next cycle. Stream to completion → no loss or reordering and wrap verified.
- Size flit 1025 with 1025 payload flits → size_err_o=1 sticky; all 1027 flits forwarded; the next packet parses correctly.
- Reset at payload flit 3 of 10 → FIFO empty, size_err_o=0; the next header is tagged sop. With PHIVERS_SINK_STATS_EN, counters read 0 after reset and 2/6 after packets of sizes 0 and 2.

Source files
------------

// File: rtl/phivers_flit_sink_pkg.sv
// Shared types for the PHIVERS flit sink: input parser states and the FIFO entry layout.
package phivers_flit_sink_pkg;

    localparam int unsigned PHIVERS_FLIT_SIZE = 32;

    typedef enum logic [1:0] {
        S_HEADER  = 2'd0,
        S_SIZE    = 2'd1,
        S_PAYLOAD = 2'd2
    } sink_state_t;

    typedef struct packed {
        logic                         sop;
        logic                         eop;
        logic [PHIVERS_FLIT_SIZE-1:0] data;
    } sink_entry_t;

endpackage

// File: rtl/phivers_sink_fifo.sv
// Show-ahead FIFO for the flit sink; rejects pushes when full and pops when empty.
module phivers_sink_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_q == CNT_FULL);
    assign empty_o   = (count_q == '0);
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    // Empty reads return zero so the output bus is clean out of reset.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next-state for pointers, occupancy and storage.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = wr_data_i;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because empty reads are masked.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/phivers_flit_sink.sv
// Credit-based flit receiver: frames header/size/payload flits into a tagged valid/ready stream.
// Optional PHIVERS_SINK_STATS_EN adds packet and flit counters.
module phivers_flit_sink
    import phivers_flit_sink_pkg::*;
#(
    parameter int unsigned FLIT_SIZE    = PHIVERS_FLIT_SIZE,
    parameter int unsigned BUFFER_DEPTH = 8,
    parameter int unsigned MAX_PAYLOAD  = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic                 credit_o,
    input  logic [FLIT_SIZE-1:0] data_i,
    output logic                 pkt_valid_o,
    input  logic                 pkt_ready_i,
    output logic [FLIT_SIZE-1:0] pkt_data_o,
    output logic                 pkt_sop_o,
    output logic                 pkt_eop_o,
    output logic                 size_err_o,
`ifdef PHIVERS_SINK_STATS_EN
    output logic [31:0]          pkt_count_o,
    output logic [31:0]          flit_count_o,
`endif
    output logic                 busy_o
);
    localparam int unsigned EW = FLIT_SIZE + 2;
    localparam logic [FLIT_SIZE-1:0] CNT_ONE  = FLIT_SIZE'(1);
    localparam logic [FLIT_SIZE-1:0] MAX_SIZE = FLIT_SIZE'(MAX_PAYLOAD);

    sink_state_t          state_q, state_d;
    logic [FLIT_SIZE-1:0] cnt_q, cnt_d;
    logic                 size_err_q, size_err_d;
    logic                 sop_s, eop_s;
    logic                 xfer_s, pop_s, full_s, empty_s;
    logic [EW-1:0]        rd_entry_s;

    assign credit_o    = !rst_i && !full_s;
    assign xfer_s      = rx_i && credit_o;
    assign pkt_valid_o = !empty_s;
    assign pop_s       = pkt_valid_o && pkt_ready_i;
    assign pkt_sop_o   = rd_entry_s[EW-1];
    assign pkt_eop_o   = rd_entry_s[EW-2];
    assign pkt_data_o  = rd_entry_s[FLIT_SIZE-1:0];
    assign size_err_o  = size_err_q;
    assign busy_o      = (state_q != S_HEADER);

    // Parser: tags each accepted flit and tracks remaining payload.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        size_err_d = size_err_q;
        sop_s      = 1'b0;
        eop_s      = 1'b0;
        case (state_q)
            S_HEADER: begin
                sop_s = 1'b1;
                if (xfer_s) begin
                    state_d = S_SIZE;
                end else begin
                    state_d = S_HEADER;
                end
            end
            S_SIZE: begin
                eop_s = (data_i == '0);
                if (xfer_s) begin
                    cnt_d      = data_i;
                    size_err_d = size_err_q || (data_i > MAX_SIZE);
                    state_d    = (data_i == '0) ? S_HEADER : S_PAYLOAD;
                end else begin
                    state_d = S_SIZE;
                end
            end
            S_PAYLOAD: begin
                eop_s = (cnt_q == CNT_ONE);
                if (xfer_s) begin
                    cnt_d   = cnt_q - CNT_ONE;
                    state_d = (cnt_q == CNT_ONE) ? S_HEADER : S_PAYLOAD;
                end else begin
                    state_d = S_PAYLOAD;
                end
            end
            default: begin
                state_d = S_HEADER;
            end
        endcase
    end

    // Parser state, payload counter and sticky size error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_HEADER;
            cnt_q      <= '0;
            size_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            size_err_q <= size_err_d;
        end
    end

    phivers_sink_fifo #(
        .WIDTH (EW),
        .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (xfer_s),
        .wr_data_i ({sop_s, eop_s, data_i}),
        .pop_i     (pop_s),
        .rd_data_o (rd_entry_s),
        .full_o    (full_s),
        .empty_o   (empty_s)
    );

`ifdef PHIVERS_SINK_STATS_EN
    logic [31:0] pkt_count_q, pkt_count_d;
    logic [31:0] flit_count_q, flit_count_d;

    assign pkt_count_o  = pkt_count_q;
    assign flit_count_o = flit_count_q;

    // Statistics next-state; counters wrap naturally.
    always_comb begin
        pkt_count_d  = pkt_count_q;
        flit_count_d = flit_count_q;
        if (pop_s && pkt_eop_o) begin
            pkt_count_d = pkt_count_q + 32'd1;
        end else begin
            pkt_count_d = pkt_count_q;
        end
        if (xfer_s) begin
            flit_count_d = flit_count_q + 32'd1;
        end else begin
            flit_count_d = flit_count_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pkt_count_q  <= 32'd0;
            flit_count_q <= 32'd0;
        end else begin
            pkt_count_q  <= pkt_count_d;
            flit_count_q <= flit_count_d;
        end
    end
`endif

endmodule
